// File: rtl/spi_master_if.sv
// spi_master_if: host handshake plus SPI pin bundle for spi_master.
// master modport is the spi_master view; slave modport is the host/peripheral view.
interface spi_master_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              hold_cs;
  logic              end_xfer;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              sck;
  logic              ncs;
  logic              mosi;
  logic              miso;

  modport master (
    input  start, tx_data, hold_cs, end_xfer, miso,
    output rx_data, rx_valid, busy, sck, ncs, mosi
  );

  modport slave (
    output start, tx_data, hold_cs, end_xfer, miso,
    input  rx_data, rx_valid, busy, sck, ncs, mosi
  );
endinterface

// File: rtl/spi_master.sv
// spi_master: SPI mode-0 master, MSB first, one word per start, optional held chip select.
// Define SPI_MISO_SYNC_EN to pass miso through a 2-flop synchroniser (needs CLK_DIV >= 3).
module spi_master #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 5,
  parameter int GAP_CYC = 10
) (
  input  logic         clk,
  input  logic         nrst,
  spi_master_if.master bus,
  output logic [2:0]   state_dbg
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

`ifdef SPI_MISO_SYNC_EN
  if (CLK_DIV < 3) begin : g_bad_div
    $error("spi_master: CLK_DIV must be >= 3 with the miso synchroniser");
  end
`else
  if (CLK_DIV < 2) begin : g_bad_div
    $error("spi_master: CLK_DIV must be >= 2");
  end
`endif
  if (GAP_CYC < 2) begin : g_bad_gap
    $error("spi_master: GAP_CYC must be >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT   = 3'd1,
    S_HOLD    = 3'd2,
    S_CS_HELD = 3'd3,
    S_GAP     = 3'd4
  } state_t;

  // Handshake: start is taken on any clk edge where busy=0 (IDLE or CS_HELD), and
  // tx_data/hold_cs are captured on that same edge; start while busy=1 is dropped.
  // rx_valid is a one-cycle strobe with no back-pressure; rx_data holds until the next one.

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                hold_q, hold_d;
  logic                sck_q, sck_d;
  logic                ncs_q, ncs_d;
  logic                mosi_q, mosi_d;
  logic                busy_q, busy_d;
  logic                rx_valid_q, rx_valid_d;

  logic div_last;
  logic gap_last;
  logic rise_now;
  logic samp_en;
  logic samp_bit;

  assign div_last = (div_cnt_q == DIV_W'(CLK_DIV - 1));
  assign gap_last = (gap_cnt_q == GAP_W'(GAP_CYC - 1));
  // True on the clk edge that drives sck from low to high.
  assign rise_now = (state_q == S_SHIFT) && !sck_q && div_last;

`ifdef SPI_MISO_SYNC_EN
  logic [1:0] miso_sync_q;
  logic [1:0] samp_dly_q;

  // Sampling trails the sck rise by the two synchroniser stages.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      miso_sync_q <= 2'b00;
      samp_dly_q  <= 2'b00;
    end else begin
      miso_sync_q <= {miso_sync_q[0], bus.miso};
      samp_dly_q  <= {samp_dly_q[0], rise_now};
    end
  end

  assign samp_en  = samp_dly_q[1];
  assign samp_bit = miso_sync_q[1];
`else
  assign samp_en  = rise_now;
  assign samp_bit = bus.miso;
`endif

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    rx_data_d  = rx_data_q;
    hold_d     = hold_q;
    sck_d      = sck_q;
    ncs_d      = ncs_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    rx_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE, S_CS_HELD: begin
        if (bus.start) begin
          state_d   = S_SHIFT;
          shreg_d   = bus.tx_data;
          hold_d    = bus.hold_cs;
          mosi_d    = bus.tx_data[DATA_W-1];
          ncs_d     = 1'b0;
          busy_d    = 1'b1;
          sck_d     = 1'b0;
          div_cnt_d = '0;
          bit_cnt_d = '0;
        end else if ((state_q == S_CS_HELD) && bus.end_xfer) begin
          state_d   = S_GAP;
          ncs_d     = 1'b1;
          busy_d    = 1'b1;
          gap_cnt_d = '0;
        end
      end

      S_SHIFT: begin
        // The shift register doubles as tx source (MSB side) and rx sink (LSB side).
        if (samp_en) begin
          shreg_d = {shreg_q[DATA_W-2:0], samp_bit};
        end
        if (div_last) begin
          div_cnt_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            sck_d     = 1'b0;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
              state_d = S_HOLD;
            end else begin
              mosi_d = shreg_q[DATA_W-1];
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      S_HOLD: begin
        if (div_last) begin
          div_cnt_d  = '0;
          rx_data_d  = shreg_q;
          rx_valid_d = 1'b1;
          if (hold_q) begin
            state_d = S_CS_HELD;
            busy_d  = 1'b0;
          end else begin
            state_d   = S_GAP;
            ncs_d     = 1'b1;
            gap_cnt_d = '0;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      S_GAP: begin
        if (gap_last) begin
          state_d   = S_IDLE;
          busy_d    = 1'b0;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        sck_d   = 1'b0;
        ncs_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      div_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      rx_data_q  <= '0;
      hold_q     <= 1'b0;
      sck_q      <= 1'b0;
      ncs_q      <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      rx_data_q  <= rx_data_d;
      hold_q     <= hold_d;
      sck_q      <= sck_d;
      ncs_q      <= ncs_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign bus.sck      = sck_q;
  assign bus.ncs      = ncs_q;
  assign bus.mosi     = mosi_q;
  assign bus.busy     = busy_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;
  assign state_dbg    = state_q;

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
SPI mode-0 master that generates sck, ncs and mosi from the system clock and samples miso, shifting MSB first. It is the initiator-side counterpart of the team's SPI slave synchroniser and drives the slave FPGA or board peripherals. Sck timing respects the slave's F_SPI <= F_CLK/10 requirement at default parameters. A host-side start/busy/rx_valid handshake moves one word per transaction, and ncs can be held low across multi-word transfers.

Parameters:
DATA_W, 8, bits per word; MSB shifted first.
CLK_DIV, 5, clk cycles per sck half-period; legal range >= 2 (>= 3 with SPI_MISO_SYNC_EN). Default gives sck = clk/10.
GAP_CYC, 10, minimum clk cycles ncs stays high between transactions; legal range >= 2.

Ports:
clk  in  1  system clock; all logic on posedge
nrst  in  1  asynchronous active-low reset
start  in  1  request one word transfer; accepted only when busy=0
tx_data  in  DATA_W  word to send; captured on the accepted start cycle
hold_cs  in  1  captured with start; 1 keeps ncs low after this word
end_xfer  in  1  releases a held ncs; honoured only in CS_HELD
rx_data  out  DATA_W  last received word; holds its value until the next rx_valid
rx_valid  out  1  one-cycle strobe when rx_data is updated
busy  out  1  high while a word is in flight or the ncs gap is running
sck  out  1  SPI clock; idles low (CPOL=0)
ncs  out  1  chip select, active low
mosi  out  1  master data out; changes only while sck is low
miso  in  1  slave data in; asynchronous to clk

Behaviour:
- Reset (async, nrst=0): state IDLE, sck=0, ncs=1, mosi=0, busy=0, rx_valid=0, rx_data=0, all counters 0. All outputs are registered.
- States: IDLE, SHIFT, HOLD, CS_HELD, GAP.
- IDLE: start=1 at cycle T captures tx_data and hold_cs and moves to SHIFT. At T+1: ncs=0, busy=1, mosi=tx_data[DATA_W-1], sck=0.
- SHIFT: each bit is one low phase of CLK_DIV cycles followed by one high phase of CLK_DIV cycles.
  - On a low-to-high sck transition, miso is sampled into the shift register LSB.
  - On a high-to-low transition, mosi takes the next bit, except after the last bit.
  - After DATA_W high phases, sck goes low and the state moves to HOLD.
- HOLD: lasts CLK_DIV cycles with sck=0. On exit:
  - rx_data is loaded and rx_valid pulses for exactly one cycle.
  - If hold_cs=0: ncs=1 on that same cycle and the state moves to GAP.
  - If hold_cs=1: the state moves to CS_HELD.
- Latency: from the accepted start at T, rx_valid occurs at T+1+(2*DATA_W+1)*CLK_DIV.
- GAP: ncs=1, busy=1 for GAP_CYC cycles, then IDLE with busy=0.
- CS_HELD: ncs=0, sck=0, busy=0.
  - start enters SHIFT exactly as from IDLE; ncs stays low.
  - end_xfer=1 without start: ncs=1 next cycle, then GAP.
  - If start and end_xfer are both 1 on the same cycle, start wins and end_xfer is ignored.
- start while busy=1 is ignored; no queueing. end_xfer outside CS_HELD is ignored.
- Bit counter width is clog2(DATA_W+1). The half-period counter counts 0..CLK_DIV-1 and wraps.
- Reset mid-transfer: outputs go immediately (asynchronously) to their reset values. ncs rising mid-word is the slave's abort condition.
- The busy span of a non-held word is (2*DATA_W+1)*CLK_DIV + GAP_CYC cycles.

Optional Feature:
SPI_MISO_SYNC_EN
- Defined:
  - miso passes through a 2-flop synchroniser.
  - Sampling moves to 2 clk cycles after each sck rising edge, to compensate for the synchroniser.
  - Requires CLK_DIV >= 3.
  - rx_valid timing is unchanged.
- Undefined: raw miso is sampled on the clk cycle in which sck is driven high. The slave must hold miso stable through the high phase.

Test Plan:
- Reset, then start with tx_data=8'hA5, hold_cs=0, miso looped to mosi:
  - mosi sequence is 1,0,1,0,0,1,0,1.
  - 8 sck pulses, each 5 cycles high and 5 low.
  - rx_valid at T+86 with rx_data=8'hA5.
  - ncs rises at T+86; busy drops at T+96.
- miso tied to 1 and start with tx_data=8'h00: rx_data=8'hFF; mosi stays 0; sck period is 10 clk.
- Two words with hold_cs=1 (8'h12, then 8'h34), then end_xfer:
  - ncs stays low between words; busy is 0 in CS_HELD.
  - ncs rises one cycle after end_xfer, followed by a 10-cycle GAP.
- start pulsed at T+20 during a transfer: ignored; exactly 8 sck pulses occur and no second rx_valid.
- nrst asserted at T+40 mid-word: sck=0, ncs=1, busy=0 immediately; a following start gives a clean full transfer.
- With SPI_MISO_SYNC_EN, CLK_DIV=3, and a slave model changing miso on sck falling edges with data 8'h3C: rx_data=8'h3C and rx_valid at T+1+17*3.
